// File: rtl/alu_pkg.sv
// Purpose: shared opcode encoding and decode helpers for the registered ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int XLEN = 32;

  // opcode = {class[3:0], funct3[2:0]}
  typedef logic [6:0] opcode_t;

  localparam logic [3:0] CLS_BASE = 4'b0000;
  localparam logic [3:0] CLS_ALT  = 4'b0100;
  localparam logic [3:0] CLS_MUL  = 4'b0001;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_MUL     = 3'b000;
  localparam logic [2:0] F3_MULH    = 3'b001;
  localparam logic [2:0] F3_MULHSU  = 3'b010;
  localparam logic [2:0] F3_MULHU   = 3'b011;

  function automatic logic [3:0] op_class(input opcode_t op);
    return op[6:3];
  endfunction

  function automatic logic [2:0] op_funct3(input opcode_t op);
    return op[2:0];
  endfunction

endpackage

// File: rtl/alu_mul.sv
// Purpose: combinational multiplier returning the low or high word of the 64-bit product.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a, b - 32-bit operands; funct3 - selects MUL/MULH/MULHSU/MULHU;
//        result - selected 32-bit product word (1xx funct3 is filtered by the caller).
module alu_mul
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic        a_signed;
  logic        b_signed;
  logic [32:0] a_ext;
  logic [32:0] b_ext;
  logic [63:0] a_wide;
  logic [63:0] b_wide;
  logic [63:0] prod;

  // One 33x33 signed multiplier covers all signedness variants: the extra
  // top bit is either the sign bit or zero depending on the operation.
  assign a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
  assign b_signed = (funct3 == F3_MULH);

  assign a_ext = {a_signed & a[31], a};
  assign b_ext = {b_signed & b[31], b};

  // The true product of two 33-bit signed values fits in 64 bits here, so a
  // 64-bit wrap-around multiply of the sign-extended operands is exact.
  assign a_wide = {{31{a_ext[32]}}, a_ext};
  assign b_wide = {{31{b_ext[32]}}, b_ext};
  assign prod   = a_wide * b_wide;

  assign result = (funct3 == F3_MUL) ? prod[31:0] : prod[63:32];

endmodule

// File: rtl/alu_reg_unit.sv
// Purpose: RV32I reg-reg ALU plus RV32M multiply subset with a registered result.
// Latency: 1 cycle from inputs sampled at rising clk to result.
// Backpressure: none; accepts one operation every cycle.
// Ports: clk, rst (async, active-high); a, b - operands rs1/rs2;
//        opcode - {class, funct3}; result - registered ALU output.
module alu_reg_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [6:0]  opcode,
  output logic [31:0] result
);

  logic [3:0]  cls;
  logic [2:0]  f3;
  logic [4:0]  shamt;
  logic [31:0] mul_res;
  logic [31:0] sra_res;
  logic [31:0] alu_next;

  assign cls   = op_class(opcode_t'(opcode));
  assign f3    = op_funct3(opcode_t'(opcode));
  assign shamt = b[4:0];

  assign sra_res = $unsigned($signed(a) >>> shamt);

  alu_mul u_mul (
    .a      (a),
    .b      (b),
    .funct3 (f3),
    .result (mul_res)
  );

  always_comb begin
    alu_next = '0;
    unique case (cls)
      CLS_BASE: begin
        unique case (f3)
          F3_ADD_SUB: alu_next = a + b;
          F3_SLL:     alu_next = a << shamt;
          F3_SLT:     alu_next = {31'b0, ($signed(a) < $signed(b))};
          F3_SLTU:    alu_next = {31'b0, (a < b)};
          F3_XOR:     alu_next = a ^ b;
          F3_SRL_SRA: alu_next = a >> shamt;
          F3_OR:      alu_next = a | b;
          F3_AND:     alu_next = a & b;
          default:    alu_next = '0;
        endcase
      end
      CLS_ALT: begin
        if (f3 == F3_ADD_SUB)      alu_next = a - b;
        else if (f3 == F3_SRL_SRA) alu_next = sra_res;
        else                       alu_next = '0;
      end
      // funct3 1xx in the multiply class is not a defined operation
      CLS_MUL:  alu_next = f3[2] ? '0 : mul_res;
      default:  alu_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) result <= '0;
    else     result <= alu_next;
  end

endmodule

// File: tb/tb_alu_reg_unit.sv
module tb_alu_reg_unit;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [6:0]  opcode;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  alu_reg_unit dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference model, written from the operation table.
  function automatic logic [31:0] model(input logic [6:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, sy, zx, zy, p;
    logic [31:0] r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    zx = {32'b0, x};
    zy = {32'b0, y};
    r  = 32'h0;
    case (op)
      7'b0000000: r = x + y;
      7'b0000001: r = x << y[4:0];
      7'b0000010: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      7'b0000011: r = (x < y) ? 32'd1 : 32'd0;
      7'b0000100: r = x ^ y;
      7'b0000101: r = x >> y[4:0];
      7'b0000110: r = x | y;
      7'b0000111: r = x & y;
      7'b0100000: r = x - y;
      7'b0100101: begin p = sx >> y[4:0]; r = p[31:0]; end
      7'b0001000: begin p = zx * zy; r = p[31:0]; end
      7'b0001001: begin p = sx * sy; r = p[63:32]; end
      7'b0001010: begin p = sx * zy; r = p[63:32]; end
      7'b0001011: begin p = zx * zy; r = p[63:32]; end
      default:    r = 32'h0;
    endcase
    return r;
  endfunction

  // Drive one operation for the next rising edge and record its expected result.
  task automatic drive(input logic [6:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e, input string nm);
    @(negedge clk);
    opcode = op;
    a      = x;
    b      = y;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    a      = 32'hFF00FF00;
    b      = 32'h00FF00FF;
    opcode = 7'b0000000;
    #3;
    n_cmp++;
    if (result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_async: got %h expected %h", result, 32'h0);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (result !== 32'h0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, result, 32'h0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (result !== 32'hFFFFFFFF) begin
      n_err++;
      $display("FAIL reset_first_edge: got %h expected %h", result, 32'hFFFFFFFF);
    end
  endtask

  task automatic test_directed();
    logic [6:0]  ops [13] = '{7'b0000000, 7'b0100000, 7'b0000001, 7'b0000101, 7'b0100101,
                              7'b0000010, 7'b0000011, 7'b0001000, 7'b0001001, 7'b0001010,
                              7'b0001011, 7'b1111111, 7'b0001100};
    logic [31:0] xs  [13] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h80000000,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'h12345678, 32'h12345678};
    logic [31:0] ys  [13] = '{32'h1, 32'h1, 32'h21, 32'h21, 32'h21,
                              32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'h9ABCDEF0, 32'h9ABCDEF0};
    logic [31:0] es  [13] = '{32'h0, 32'hFFFFFFFE, 32'h0, 32'h40000000, 32'hC0000000,
                              32'h1, 32'h0, 32'h1, 32'h0, 32'hFFFFFFFF,
                              32'hFFFFFFFE, 32'h0, 32'h0};
    string       nms [13] = '{"add_wrap", "sub_wrap", "sll_amt1", "srl_amt1", "sra_amt1",
                              "slt", "sltu", "mul", "mulh", "mulhsu",
                              "mulhu", "illegal_7f", "illegal_mul1xx"};
    logic [31:0] e;
    string       nm;
    for (int i = 0; i < 13; i++) begin
      drive(ops[i], xs[i], ys[i], es[i], nms[i]);
      @(posedge clk); #1;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if (result !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", nm, result, e);
      end
    end
  endtask

  task automatic test_sampling();
    logic [31:0] e;
    string       nm;
    drive(7'b0000111, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, "and_sample");
    @(posedge clk); #1;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    n_cmp++;
    if (result !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, result, e);
    end
    #1;
    a      = 32'hFFFFFFFF;
    b      = 32'hFFFFFFFF;
    opcode = 7'b0000110;
    #2;
    n_cmp++;
    if (result !== 32'h0000F000) begin
      n_err++;
      $display("FAIL mid_cycle_hold: got %h expected %h", result, 32'h0000F000);
    end
  endtask

  task automatic test_midstream_reset();
    logic [31:0] e;
    string       nm;
    drive(7'b0000000, 32'h1, 32'h2, 32'h3, "add_pre_reset");
    @(posedge clk); #1;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    n_cmp++;
    if (result !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, result, e);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (result !== 32'h0) begin
      n_err++;
      $display("FAIL midstream_async_clear: got %h expected %h", result, 32'h0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (result !== 32'h0) begin
      n_err++;
      $display("FAIL midstream_hold: got %h expected %h", result, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(7'b0000110, 32'h000000F0, 32'h0000000F, 32'h000000FF, "or_post_reset");
    @(posedge clk); #1;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    n_cmp++;
    if (result !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, result, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [16] = '{7'b0000000, 7'b0000001, 7'b0000010, 7'b0000011,
                             7'b0000100, 7'b0000101, 7'b0000110, 7'b0000111,
                             7'b0100000, 7'b0100101, 7'b0001000, 7'b0001001,
                             7'b0001010, 7'b0001011, 7'b0100001, 7'b1000000};
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 48; i++) begin
          logic [6:0]  op;
          logic [31:0] x, y;
          op = ops[$urandom_range(15, 0)];
          x  = $urandom;
          y  = $urandom;
          if (i % 8 == 0) x = 32'h80000000;
          if (i % 8 == 1) y = 32'hFFFFFFFF;
          drive(op, x, y, model(op, x, y), $sformatf("b2b[%0d] op=%b", i, op));
        end
      end
      begin
        for (int j = 0; j < 48; j++) begin
          logic [31:0] e;
          string       nm;
          @(posedge clk); #1;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL b2b_empty[%0d]: got %h expected <queued result>", j, result);
          end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (result !== e) begin
              n_err++;
              $display("FAIL %s: got %h expected %h", nm, result, e);
            end
          end
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sampling();
    test_midstream_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_reg_unit.md
# alu_reg_unit

Registered 32-bit integer ALU for the decode/execute stage. It takes two register operands and a 7-bit operation select and produces a single 32-bit result, captured in an output register one clock after the inputs are presented. It implements the RV32I register-register operations plus the RV32M multiply subset, and feeds the writeback path.

## Interface
- Parameters: none; width is fixed at 32 bits and the operation encoding is fixed.
- Clocking: one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk` in 1 — rising-edge clock.
- `rst` in 1 — asynchronous, active-high reset.
- `a` in 32 — operand A (rs1).
- `b` in 32 — operand B (rs2).
- `opcode` in 7 — operation select, `{class[3:0], funct3[2:0]}`.
- `result` out 32 — registered ALU result.

## Operation
- Class `0000`:
  - funct3 000 ADD: a+b, mod 2^32.
  - 001 SLL: a << b[4:0].
  - 010 SLT: signed compare; result is 1 or 0.
  - 011 SLTU: unsigned compare; result is 1 or 0.
  - 100 XOR.
  - 101 SRL: logical right shift by b[4:0].
  - 110 OR.
  - 111 AND.
- Class `0100`:
  - 000 SUB: a−b, mod 2^32.
  - 101 SRA: arithmetic right shift by b[4:0].
  - Other funct3 values are undefined.
- Class `0001`: 64-bit product, low or high word.
  - 000 MUL: low 32 bits; signedness irrelevant.
  - 001 MULH: high 32 bits, signed×signed.
  - 010 MULHSU: high 32 bits, signed a × unsigned b.
  - 011 MULHU: high 32 bits, unsigned×unsigned.
  - 1xx: undefined.
- Undefined encodings, including all other class values, produce `result` = 0.
- Shift amounts use only b[4:0]; b[31:5] is ignored.
- No overflow or flag outputs; arithmetic wraps silently.
- Datapath is purely combinational up to the single output register; no internal state besides `result`.

## Timing
- `result` resets to 32'h0000_0000 immediately on `rst` assertion, with no clock needed.
- While `rst` is high, `result` holds 0 regardless of inputs or clock edges.
- After `rst` deasserts, the first rising `clk` captures f(opcode, a, b).
- Latency is exactly 1 cycle. Throughput is one operation per cycle; no handshake or stall.
- Inputs are sampled only at the rising edge; changes between edges do not affect `result`.
- `rst` asserted mid-stream: `result` clears at once. The next post-reset edge reflects the inputs present at that edge.
- The full combinational path, including the 32×32 multiply, must close timing in one cycle.

## Structure
- Shared package `alu_pkg` holds:
  - 4-bit class constants: `CLS_BASE`=0000, `CLS_ALT`=0100, `CLS_MUL`=0001.
  - 3-bit funct3 constants: `F3_ADD_SUB`, `F3_SLL`, `F3_SLT`, `F3_SLTU`, `F3_XOR`, `F3_SRL_SRA`, `F3_OR`, `F3_AND`, `F3_MUL`, `F3_MULH`, `F3_MULHSU`, `F3_MULHU`.
  - A typedef for the 7-bit opcode.
- One sub-module, `alu_mul`, is natural: a combinational 33×33 signed multiplier using sign/zero-extended operands selected by funct3, returning the 32-bit selected word.
- Top level contains the decode mux, the shifter/logic/compare logic, and the output register.

## Test plan
- Reset: assert `rst` with a=FF00FF00, b=00FF00FF, opcode=0000000 → `result`=0 asynchronously; after deassert plus one edge → FFFFFFFF.
- ADD/SUB wrap: a=FFFFFFFF, b=1 with opcode 0000000 → 0; the same operands with opcode 0100000 → FFFFFFFE.
- Shifts: a=80000000, b=00000021 (amount 1). SLL → 0; SRL → 40000000; SRA → C0000000.
- Compares: a=FFFFFFFF, b=1. SLT → 1; SLTU → 0.
- Multiply: a=FFFFFFFF, b=FFFFFFFF.
  - MUL → 1.
  - MULH → 0.
  - MULHSU → FFFFFFFF.
  - MULHU → FFFFFFFE.
- Illegal opcode 1111111 → 0. Back-to-back ops on consecutive cycles must each appear exactly one cycle later.
